// File: rtl/bip_pkg.sv
// Shared opcodes, command bytes, controller state type and report-frame sizing
// for the BIP run/report controller.
package bip_pkg;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h54;
  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_LATCH = 3'd3,
    ST_SEND  = 3'd4,
    ST_WAIT  = 3'd5
  } state_e;

  function automatic int bytes_of(int width);
    return (width + 7) / 8;
  endfunction

  // Header byte plus each field rounded up to whole bytes.
  function automatic int frame_len(int pc_w, int acc_w, int cnt_w);
    return 1 + bytes_of(pc_w) + bytes_of(acc_w) + bytes_of(cnt_w);
  endfunction

  function automatic logic is_halt(logic [4:0] op);
    return (op == OP_HLT) || (op > OP_SUBI);
  endfunction

endpackage

// File: rtl/bip_frame_mux.sv
// Combinational report-frame byte selector: header, pc, acc, counter, each
// zero-extended to whole bytes and sent MSB byte first.
module bip_frame_mux
  import bip_pkg::*;
#(
  parameter  int PC_W  = 11,
  parameter  int ACC_W = 16,
  parameter  int CNT_W = 32,
  localparam int FLEN  = frame_len(PC_W, ACC_W, CNT_W),
  localparam int IDX_W = $clog2(FLEN)
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [ACC_W-1:0] i_acc,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [7:0]       o_byte
);

  localparam int PC_B  = bytes_of(PC_W);
  localparam int ACC_B = bytes_of(ACC_W);
  localparam int CNT_B = bytes_of(CNT_W);

  logic [PC_B*8-1:0]  w_pc_ext;
  logic [ACC_B*8-1:0] w_acc_ext;
  logic [CNT_B*8-1:0] w_cnt_ext;
  logic [FLEN*8-1:0]  w_frame;

  always_comb begin
    w_pc_ext              = '0;
    w_pc_ext[PC_W-1:0]    = i_pc;
    w_acc_ext             = '0;
    w_acc_ext[ACC_W-1:0]  = i_acc;
    w_cnt_ext             = '0;
    w_cnt_ext[CNT_W-1:0]  = i_cnt;
  end

  assign w_frame = {FRAME_HDR, w_pc_ext, w_acc_ext, w_cnt_ext};

  // Byte 0 is the most significant byte of the packed frame.
  always_comb begin
    o_byte = 8'h00;
    for (int b = 0; b < FLEN; b++) begin
      if (i_idx == IDX_W'(b)) o_byte = w_frame[(FLEN-1-b)*8 +: 8];
    end
  end

endmodule

// File: rtl/bip_run_controller.sv
// Run/report sequencer for the BIP processor: clears and runs it on 'R', then
// reports PC/ACC/instruction count over the UART. Define BIP_STEP_EN for 'T' single-step.
module bip_run_controller
  import bip_pkg::*;
#(
  parameter int PC_W  = 11,
  parameter int ACC_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic [4:0]       opcode,
  input  logic [PC_W-1:0]  pc,
  input  logic [ACC_W-1:0] acc,
  output logic             cpu_en,
  output logic             cpu_clr,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_done,
  output logic             busy
);

  localparam int FLEN  = frame_len(PC_W, ACC_W, CNT_W);
  localparam int IDX_W = $clog2(FLEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLEN - 1);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_cnt_snap;
  logic [PC_W-1:0]    r_pc_snap;
  logic [ACC_W-1:0]   r_acc_snap;
  logic [IDX_W-1:0]   r_idx;
  logic               r_cpu_en;
  logic               r_cpu_clr;
  logic               r_tx_start;
  logic               r_busy;
  logic               w_halt;
  logic               w_cmd_run;
  logic               w_step_go;
  logic               w_step_clr;
  logic               w_step_stop;
  logic [7:0]         w_frame_byte;

  assign w_halt    = is_halt(opcode);
  assign w_cmd_run = rx_done && (rx_data == CMD_RUN);

`ifdef BIP_STEP_EN
  logic r_step;
  logic r_need_clr;

  assign w_step_go   = rx_done && (rx_data == CMD_STEP);
  assign w_step_clr  = r_need_clr;
  assign w_step_stop = r_step;

  // A halt seen in RUN (full run or step) forces the next step to start from a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step     <= 1'b0;
      r_need_clr <= 1'b1;
    end else begin
      if (r_state == ST_IDLE && (w_cmd_run || w_step_go)) r_step <= !w_cmd_run;
      if (r_state == ST_CLEAR)                 r_need_clr <= 1'b0;
      else if (r_state == ST_RUN && w_halt)    r_need_clr <= 1'b1;
    end
  end
`else
  assign w_step_go   = 1'b0;
  assign w_step_clr  = 1'b0;
  assign w_step_stop = 1'b0;
`endif

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_run)      w_next = ST_CLEAR;
        else if (w_step_go) w_next = w_step_clr ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: w_next = ST_RUN;
      ST_RUN:   if (w_halt || w_step_stop) w_next = ST_LATCH;
      ST_LATCH: w_next = ST_SEND;
      ST_SEND:  w_next = ST_WAIT;
      ST_WAIT:  if (tx_done) w_next = (r_idx == LAST_IDX) ? ST_IDLE : ST_SEND;
      default:  w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cpu_en   <= 1'b0;
      r_cpu_clr  <= 1'b0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cpu_en   <= (w_next == ST_RUN);
      r_cpu_clr  <= (w_next == ST_CLEAR);
      r_tx_start <= (w_next == ST_SEND);
      r_busy     <= (w_next != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_cnt_snap <= '0;
      r_pc_snap  <= '0;
      r_acc_snap <= '0;
      r_idx      <= '0;
    end else begin
      if (r_state == ST_CLEAR) begin
        r_cnt <= '0;
      end else if (r_state == ST_RUN && !w_halt && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Snapshot after the last enabled cycle so a single step reports its own result.
      if (r_state == ST_LATCH) begin
        r_pc_snap  <= pc;
        r_acc_snap <= acc;
        r_cnt_snap <= r_cnt;
        r_idx      <= '0;
      end else if (r_state == ST_WAIT && tx_done && r_idx != LAST_IDX) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  bip_frame_mux #(
    .PC_W  (PC_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_frame_mux (
    .i_idx  (r_idx),
    .i_pc   (r_pc_snap),
    .i_acc  (r_acc_snap),
    .i_cnt  (r_cnt_snap),
    .o_byte (w_frame_byte)
  );

  assign cpu_en   = r_cpu_en;
  assign cpu_clr  = r_cpu_clr;
  assign tx_start = r_tx_start;
  assign busy     = r_busy;
  assign tx_data  = r_tx_start ? w_frame_byte : 8'h00;

endmodule

// File: tb/tb_bip_run_controller.sv
// Self-checking bench for bip_run_controller: behavioural BIP core, UART tx echo,
// frame scoreboard from a program-level reference model, plus literal frames.
module tb_bip_run_controller;

  localparam int PC_W  = 11;
  localparam int ACC_W = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_done = 1'b0;
  logic [4:0]       opcode;
  logic [PC_W-1:0]  pc;
  logic [ACC_W-1:0] acc;
  logic             cpu_en;
  logic             cpu_clr;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_done;
  logic             busy;
  logic             resp_done = 1'b0;
  logic             inj_done = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0]  rom_op  [16];
  logic [15:0] rom_arg [16];
  logic [15:0] cpu_mem [16];
  logic [15:0] ref_mem [16];

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int en_cycles, clr_cycles, cyc, last_en_cyc, first_tx_cyc;
  int gen = 0;

  int          s_pc;
  logic [15:0] s_acc;
  logic [31:0] s_cnt;
  bit          s_need_clr;

  assign tx_done = resp_done | inj_done;

  always #5 clk = ~clk;

  bip_run_controller #(.PC_W(PC_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .opcode   (opcode),
    .pc       (pc),
    .acc      (acc),
    .cpu_en   (cpu_en),
    .cpu_clr  (cpu_clr),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_halt(logic [4:0] op);
    return (op == 5'd0) || (op > 5'd7);
  endfunction

  function automatic logic [15:0] alu(logic [4:0] op, logic [15:0] arg,
                                      logic [15:0] a, logic [15:0] m);
    case (op)
      5'd2:    return m;
      5'd3:    return arg;
      5'd4:    return a + m;
      5'd5:    return a + arg;
      5'd6:    return a - m;
      5'd7:    return a - arg;
      default: return a;
    endcase
  endfunction

  task automatic load_prog(int id);
    for (int i = 0; i < 16; i++) begin
      rom_op[i]  = 5'd0;
      rom_arg[i] = 16'd0;
      cpu_mem[i] = 16'd0;
    end
    case (id)
      0: begin  // LDI 5; ADDI 3; STO 0; HLT
        rom_op[0] = 5'd3; rom_arg[0] = 16'd5;
        rom_op[1] = 5'd5; rom_arg[1] = 16'd3;
        rom_op[2] = 5'd1; rom_arg[2] = 16'd0;
      end
      1: ;      // HLT first
      2: begin  // longer run for disturbance test
        rom_op[0] = 5'd3; rom_arg[0] = 16'd1;
        rom_op[1] = 5'd5; rom_arg[1] = 16'd2;
        rom_op[2] = 5'd5; rom_arg[2] = 16'd3;
        rom_op[3] = 5'd5; rom_arg[3] = 16'd4;
        rom_op[4] = 5'd1; rom_arg[4] = 16'd1;
        rom_op[5] = 5'd4; rom_arg[5] = 16'd1;
        rom_op[6] = 5'd7; rom_arg[6] = 16'd5;
        rom_op[7] = 5'd6; rom_arg[7] = 16'd1;
        rom_op[8] = 5'd5; rom_arg[8] = 16'h0100;
      end
      default: begin  // LDI 7; opcode 8 halts
        rom_op[0] = 5'd3; rom_arg[0] = 16'd7;
        rom_op[1] = 5'd8;
      end
    endcase
  endtask

  // Program-level reference: interpret from a cleared core until a halt opcode.
  task automatic ref_full(output logic [31:0] rp, output logic [31:0] ra,
                          output logic [31:0] rc);
    logic [15:0] a;
    int p, c;
    a = 16'd0; p = 0; c = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'd0;
    while (p < 16 && !m_halt(rom_op[p])) begin
      if (rom_op[p] == 5'd1) ref_mem[rom_arg[p][3:0]] = a;
      else a = alu(rom_op[p], rom_arg[p], a, ref_mem[rom_arg[p][3:0]]);
      p++;
      c++;
    end
    rp = 32'(p); ra = 32'(a); rc = 32'(c);
  endtask

  task automatic push_frame(logic [31:0] p, logic [31:0] a, logic [31:0] c);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'((p >> 8) & 32'hFF));
    exp_q.push_back(8'(p & 32'hFF));
    exp_q.push_back(8'((a >> 8) & 32'hFF));
    exp_q.push_back(8'(a & 32'hFF));
    exp_q.push_back(8'((c >> 24) & 32'hFF));
    exp_q.push_back(8'((c >> 16) & 32'hFF));
    exp_q.push_back(8'((c >> 8) & 32'hFF));
    exp_q.push_back(8'(c & 32'hFF));
  endtask

  // Behavioural BIP core: enable/clear sampled mid-cycle, applied just after the edge.
  initial begin
    logic en, clr;
    logic [4:0] op;
    pc = '0; acc = '0; opcode = 5'd0;
    forever begin
      @(negedge clk);
      en = cpu_en; clr = cpu_clr; op = opcode;
      @(posedge clk);
      #1;
      if (clr) begin
        pc = '0; acc = '0;
      end else if (en && !m_halt(op)) begin
        if (op == 5'd1) cpu_mem[rom_arg[pc[3:0]][3:0]] = acc;
        else acc = alu(op, rom_arg[pc[3:0]], acc, cpu_mem[rom_arg[pc[3:0]][3:0]]);
        pc = pc + 1'b1;
      end
      opcode = rom_op[pc[3:0]];
    end
  end

  // UART transmitter stand-in: tx_done 10 clocks after each tx_start.
  initial begin
    int g;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        g = gen;
        repeat (10) @(posedge clk);
        #1;
        if (g == gen) begin
          resp_done = 1'b1;
          @(posedge clk);
          #1;
          resp_done = 1'b0;
        end
      end
    end
  end

  // Compare process: every transmitted byte against the scoreboard.
  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (cpu_en) begin
          en_cycles++;
          last_en_cyc = cyc;
        end
        if (cpu_clr) clr_cycles++;
        if (tx_start) begin
          if (got_q.size() == 0) first_tx_cyc = cyc;
          got_q.push_back(tx_data);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_tx_start: got byte %02h, none expected", tx_data);
          end else begin
            check("frame_byte", 64'(tx_data), 64'(exp_q.pop_front()));
          end
        end
        if (cpu_en || cpu_clr || tx_start) check("busy_during_activity", 64'(busy), 64'd1);
      end
    end
  end

  task automatic send_byte(logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(string name);
    bit done;
    done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1, required 0 within 3000 cycles", name);
    end
  endtask

  task automatic wait_bytes(string name, int n);
    bit done;
    done = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (got_q.size() >= n) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_bytes_timeout: got %0d bytes, required %0d", name, got_q.size(), n);
    end
  endtask

  task automatic check_outputs_zero(string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_cpu_en"}, 64'(cpu_en), 64'd0);
    check({name, "_cpu_clr"}, 64'(cpu_clr), 64'd0);
    check({name, "_tx_start"}, 64'(tx_start), 64'd0);
    check({name, "_tx_data"}, 64'(tx_data), 64'd0);
  endtask

  task automatic run_full(string name, logic [71:0] lit, bit disturb);
    logic [31:0] rp, ra, rc;
    ref_full(rp, ra, rc);
    exp_q.delete();
    got_q.delete();
    en_cycles = 0;
    clr_cycles = 0;
    push_frame(rp, ra, rc);
    send_byte(8'h52);
    check({name, "_clr_after_cmd"}, 64'(cpu_clr), 64'd1);
    check({name, "_en_in_clear"}, 64'(cpu_en), 64'd0);
    @(posedge clk);
    #1;
    check({name, "_en_2clk_after_cmd"}, 64'(cpu_en), 64'd1);
    if (disturb) begin
      @(posedge clk); #1; inj_done = 1'b1;
      @(posedge clk); #1; inj_done = 1'b0;
      @(posedge clk); #1; inj_done = 1'b1;
      @(posedge clk); #1; inj_done = 1'b0;
      wait_bytes(name, 1);
      send_byte(8'h52);
      wait_bytes(name, 3);
      send_byte(8'h52);
    end
    wait_idle(name);
    check({name, "_byte_count"}, 64'(got_q.size()), 64'd9);
    check({name, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_en_cycles"}, 64'(en_cycles), 64'(rc + 1));
    check({name, "_clr_cycles"}, 64'(clr_cycles), 64'd1);
    check({name, "_halt_to_tx"}, 64'(first_tx_cyc - last_en_cyc), 64'd2);
    check({name, "_tx_data_idle"}, 64'(tx_data), 64'd0);
    for (int i = 0; i < 9; i++) begin
      if (i < got_q.size())
        check($sformatf("%s_lit_byte%0d", name, i), 64'(got_q[i]), 64'(lit[71-8*i -: 8]));
    end
  endtask

  task automatic step_once(int k, logic [15:0] lit_acc, logic [31:0] lit_cnt);
    int exp_clr;
    logic [4:0] op;
    exp_clr = s_need_clr ? 1 : 0;
    if (s_need_clr) begin
      s_pc = 0; s_acc = 16'd0; s_cnt = 32'd0; s_need_clr = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 16'd0;
    end
    op = rom_op[s_pc];
    if (m_halt(op)) begin
      s_need_clr = 1;
    end else begin
      if (op == 5'd1) ref_mem[rom_arg[s_pc][3:0]] = s_acc;
      else s_acc = alu(op, rom_arg[s_pc], s_acc, ref_mem[rom_arg[s_pc][3:0]]);
      s_pc++;
      s_cnt++;
    end
    exp_q.delete();
    got_q.delete();
    clr_cycles = 0;
    push_frame(32'(s_pc), 32'(s_acc), s_cnt);
    send_byte(8'h54);
    wait_idle($sformatf("step%0d", k));
    check($sformatf("step%0d_byte_count", k), 64'(got_q.size()), 64'd9);
    check($sformatf("step%0d_clr_cycles", k), 64'(clr_cycles), 64'(exp_clr));
    if (got_q.size() == 9) begin
      check($sformatf("step%0d_acc_lit", k), 64'({got_q[3], got_q[4]}), 64'(lit_acc));
      check($sformatf("step%0d_cnt_lit", k),
            64'({got_q[5], got_q[6], got_q[7], got_q[8]}), 64'(lit_cnt));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion by 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rp, ra, rc;
    load_prog(0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run_full("s1_prog", 72'hA5_0003_0008_00000003, 1'b0);

    load_prog(1);
    repeat (3) @(posedge clk);
    run_full("s2_hlt_first", 72'hA5_0000_0000_00000000, 1'b0);

    load_prog(3);
    repeat (3) @(posedge clk);
    run_full("s2b_op8_halt", 72'hA5_0001_0007_00000001, 1'b0);

    load_prog(0);
    send_byte(8'h58);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("s3_busy_after_X", 64'(busy), 64'd0);
    end
    run_full("s3_after_X", 72'hA5_0003_0008_00000003, 1'b0);

    exp_q.delete();
    got_q.delete();
    ref_full(rp, ra, rc);
    push_frame(rp, ra, rc);
    send_byte(8'h52);
    wait_bytes("s4_pre_rst", 5);
    repeat (3) @(posedge clk);
    #2;
    check("s4_busy_in_wait", 64'(busy), 64'd1);
    rst_n = 1'b0;
    gen++;
    #1;
    check_outputs_zero("s4_async_rst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    run_full("s4_after_rst", 72'hA5_0003_0008_00000003, 1'b0);

    load_prog(2);
    repeat (3) @(posedge clk);
    run_full("s5_disturb", 72'hA5_0009_0105_00000009, 1'b1);

    load_prog(0);
    repeat (3) @(posedge clk);
`ifdef BIP_STEP_EN
    s_need_clr = 1;
    step_once(1, 16'h0005, 32'd1);
    step_once(2, 16'h0008, 32'd2);
    step_once(3, 16'h0008, 32'd3);
    step_once(4, 16'h0008, 32'd3);
    step_once(5, 16'h0005, 32'd1);
`else
    clr_cycles = 0;
    got_q.delete();
    send_byte(8'h54);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("t_ignored_busy", 64'(busy), 64'd0);
    end
    check("t_ignored_clr", 64'(clr_cycles), 64'd0);
    check("t_ignored_bytes", 64'(got_q.size()), 64'd0);
`endif

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
